// File: rtl/fbcpu_ram_loader.sv
// FBCPU program/data RAM with a streaming boot loader in front of it.
// The loader owns the RAM and holds the CPU in reset until an image is in place.
module fbcpu_ram_loader #(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 10,
   parameter int LOAD_WORDS    = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] MAR,
   input  logic [DATA_WIDTH-1:0]    MDRIn,
   input  logic                     RAMWr,
   output logic [DATA_WIDTH-1:0]    MDROut,
   output logic                     cpu_rst,
   input  logic                     load_start,
   input  logic                     run_start,
   input  logic                     load_valid,
   input  logic [DATA_WIDTH-1:0]    load_data,
   output logic                     load_ready,
   output logic [ADDRESS_WIDTH:0]   load_count,
   output logic                     load_done,
   output logic [1:0]               dbg_state_o
);

   localparam int DEPTH = 1 << ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH:0] COUNT_LAST = (ADDRESS_WIDTH+1)'(LOAD_WORDS - 1);
   localparam logic [ADDRESS_WIDTH:0] COUNT_FULL = (ADDRESS_WIDTH+1)'(LOAD_WORDS);
   localparam logic [ADDRESS_WIDTH:0] COUNT_ONE  = (ADDRESS_WIDTH+1)'(1);

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Handshake: a word moves when load_valid and load_ready are both high on
   // a rising edge; load_ready is registered and high exactly while in LOAD.
   state_t                   state_q, state_d;
   logic                     cpu_rst_q, cpu_rst_d;
   logic                     load_ready_q, load_ready_d;
   logic [ADDRESS_WIDTH:0]   count_q, count_d;
   logic                     done_q, done_d;
   logic [DATA_WIDTH-1:0]    mdr_q;
   logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

   logic handshake;
   logic load_wr;
   logic cpu_wr;

   assign handshake = load_valid & load_ready_q & (count_q != COUNT_FULL);
   // A load_start in the same cycle as a handshake wins and drops the word.
   assign load_wr   = handshake & ~load_start & ~rst;
   assign cpu_wr    = (state_q == ST_RUN) & RAMWr & ~rst;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = done_q;
      unique case (state_q)
         ST_HOLD: begin
            if (load_start) begin
               state_d = ST_LOAD;
               count_d = '0;
            end else if (run_start) begin
               state_d = ST_RUN;
            end
         end
         ST_LOAD: begin
            if (load_start) begin
               count_d = '0;
            end else if (handshake) begin
               count_d = count_q + COUNT_ONE;
               if (count_q == COUNT_LAST) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (load_start) begin
               state_d = ST_LOAD;
               count_d = '0;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
      cpu_rst_d    = (state_d != ST_RUN);
      load_ready_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_HOLD;
         cpu_rst_q    <= 1'b1;
         load_ready_q <= 1'b0;
         count_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cpu_rst_q    <= cpu_rst_d;
         load_ready_q <= load_ready_d;
         count_q      <= count_d;
         done_q       <= done_d;
      end
   end

   // Read-before-write: the read samples the array before this edge's write.
   always_ff @(posedge clk) begin
      if (rst) begin
         mdr_q <= '0;
      end else begin
         mdr_q <= mem_q[MAR];
      end
   end

   // RAM contents survive reset, so the array itself has no reset branch.
   always_ff @(posedge clk) begin
      if (load_wr) begin
         mem_q[count_q[ADDRESS_WIDTH-1:0]] <= load_data;
      end else if (cpu_wr) begin
         mem_q[MAR] <= MDRIn;
      end
   end

   assign MDROut      = mdr_q;
   assign cpu_rst     = cpu_rst_q;
   assign load_ready  = load_ready_q;
   assign load_count  = count_q;
   assign load_done   = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fbcpu_ram_loader.sv
// Bench for fbcpu_ram_loader: directed vector table, multi-cycle sequences,
// then randomized traffic against a cycle-level reference model of the RAM/loader.
module tb_fbcpu_ram_loader;

   localparam int AW = 6;
   localparam int DW = 10;
   localparam int NW = 64;
   localparam int M_HOLD = 0;
   localparam int M_LOAD = 1;
   localparam int M_RUN  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] MAR;
   logic [DW-1:0] MDRIn;
   logic          RAMWr;
   logic [DW-1:0] MDROut;
   logic          cpu_rst;
   logic          load_start;
   logic          run_start;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_ready;
   logic [AW:0]   load_count;
   logic          load_done;
   logic [1:0]    dbg_state;

   fbcpu_ram_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_WORDS(NW)) dut (
      .clk(clk), .rst(rst), .MAR(MAR), .MDRIn(MDRIn), .RAMWr(RAMWr),
      .MDROut(MDROut), .cpu_rst(cpu_rst), .load_start(load_start),
      .run_start(run_start), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .load_count(load_count), .load_done(load_done),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model
   int          m_state;
   int          m_count;
   bit          m_done;
   logic [DW-1:0] m_mdr;
   bit          m_mdr_known;
   logic [DW-1:0] m_mem [NW];
   bit          m_known [NW];

   typedef struct {
      logic          rst, ls, rs, lv;
      logic [DW-1:0] ld;
      logic          ex_cpu_rst, ex_ready;
      logic [AW:0]   ex_count;
      logic          ex_done;
   } vec_t;

   vec_t tbl [15];
   logic [DW-1:0] img  [NW];
   logic [DW-1:0] img2 [NW];
   logic [DW-1:0] prog [NW];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply the rules to the inputs present just before the coming edge.
   task automatic model_edge();
      if (rst) begin
         m_state = M_HOLD; m_count = 0; m_done = 0; m_mdr = '0; m_mdr_known = 1;
      end else begin
         m_mdr = m_mem[MAR];
         m_mdr_known = m_known[MAR];
         if (m_state == M_HOLD) begin
            if (load_start) begin m_state = M_LOAD; m_count = 0; end
            else if (run_start) m_state = M_RUN;
         end else if (m_state == M_LOAD) begin
            if (load_start) m_count = 0;
            else if (load_valid) begin
               m_mem[m_count] = load_data;
               m_known[m_count] = 1;
               m_count++;
               if (m_count == NW) begin m_state = M_RUN; m_done = 1; end
            end
         end else begin
            if (RAMWr) begin m_mem[MAR] = MDRIn; m_known[MAR] = 1; end
            if (load_start) begin m_state = M_LOAD; m_count = 0; m_done = 0; end
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("cpu_rst", {31'd0, cpu_rst}, {31'd0, m_state != M_RUN});
      check("load_ready", {31'd0, load_ready}, {31'd0, m_state == M_LOAD});
      check("load_count", {25'd0, load_count}, m_count);
      check("load_done", {31'd0, load_done}, {31'd0, m_done});
      if (m_mdr_known) check("mdr", {22'd0, MDROut}, {22'd0, m_mdr});
   endtask

   task automatic idle_inputs();
      rst = 0; load_start = 0; run_start = 0; load_valid = 0; RAMWr = 0;
   endtask

   task automatic do_reset();
      idle_inputs(); rst = 1; step(); rst = 0;
   endtask

   task automatic load_image(input logic [DW-1:0] data [NW]);
      idle_inputs(); load_start = 1; step(); load_start = 0;
      for (int i = 0; i < NW; i++) begin
         load_valid = 1; load_data = data[i]; step();
      end
      load_valid = 0;
   endtask

   initial begin
      for (int i = 0; i < NW; i++) m_known[i] = 0;
      m_mdr_known = 0; m_state = M_HOLD; m_count = 0; m_done = 0; m_mdr = '0;
      MAR = '0; MDRIn = '0; load_data = '0;
      idle_inputs();

      //          rst ls rs lv ld      cpu_rst ready count done
      tbl[0]  = '{1, 0, 0, 0, 10'h000, 1, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 10'h000, 1, 0, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 10'h000, 1, 0, 0, 0};
      tbl[3]  = '{0, 0, 0, 1, 10'h011, 1, 0, 0, 0};
      tbl[4]  = '{0, 1, 1, 0, 10'h000, 1, 1, 0, 0};
      tbl[5]  = '{0, 0, 0, 1, 10'h021, 1, 1, 1, 0};
      tbl[6]  = '{0, 0, 0, 0, 10'h000, 1, 1, 1, 0};
      tbl[7]  = '{0, 0, 0, 1, 10'h022, 1, 1, 2, 0};
      tbl[8]  = '{0, 1, 0, 1, 10'h3FF, 1, 1, 0, 0};
      tbl[9]  = '{0, 0, 0, 1, 10'h023, 1, 1, 1, 0};
      tbl[10] = '{1, 0, 0, 1, 10'h024, 1, 0, 0, 0};
      tbl[11] = '{0, 0, 1, 0, 10'h000, 0, 0, 0, 0};
      tbl[12] = '{0, 0, 1, 0, 10'h000, 0, 0, 0, 0};
      tbl[13] = '{0, 1, 0, 0, 10'h000, 1, 1, 0, 0};
      tbl[14] = '{1, 0, 0, 0, 10'h000, 1, 0, 0, 0};

      // Directed table: reset, priorities, dropped word, run_start paths
      for (int i = 0; i < 15; i++) begin
         rst = tbl[i].rst; load_start = tbl[i].ls; run_start = tbl[i].rs;
         load_valid = tbl[i].lv; load_data = tbl[i].ld; RAMWr = 0; MAR = '0;
         step();
         check($sformatf("tbl%0d_cpu_rst", i), {31'd0, cpu_rst}, {31'd0, tbl[i].ex_cpu_rst});
         check($sformatf("tbl%0d_ready", i), {31'd0, load_ready}, {31'd0, tbl[i].ex_ready});
         check($sformatf("tbl%0d_count", i), {25'd0, load_count}, {25'd0, tbl[i].ex_count});
         check($sformatf("tbl%0d_done", i), {31'd0, load_done}, {31'd0, tbl[i].ex_done});
         if (tbl[i].rst) check($sformatf("tbl%0d_mdr_rst", i), {22'd0, MDROut}, 32'd0);
      end

      // Full streamed load, data = i*3, valid every cycle
      idle_inputs(); load_start = 1; step(); load_start = 0;
      for (int i = 0; i < NW; i++) begin
         check("t2_ready_before_hs", {31'd0, load_ready}, 32'd1);
         load_valid = 1; load_data = DW'(i * 3); step();
         if (i < NW - 1) check("t2_count", {25'd0, load_count}, i + 1);
      end
      load_valid = 0;
      check("t2_count_final", {25'd0, load_count}, 32'd64);
      check("t2_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      check("t2_done", {31'd0, load_done}, 32'd1);
      check("t2_ready_low", {31'd0, load_ready}, 32'd0);
      MAR = 6'd5; step();
      check("t2_mdr_addr5", {22'd0, MDROut}, 32'd15);

      // Load with valid toggling: count moves only on handshakes
      do_reset();
      load_start = 1; step(); load_start = 0;
      begin
         int acc = 0;
         int cyc = 0;
         while (acc < NW && cyc < 400) begin
            load_valid = cyc[0];
            load_data = DW'($urandom_range(0, 1023));
            if (load_valid) img[acc] = load_data;
            step();
            if (load_valid) acc++;
            check("t3_count", {25'd0, load_count}, acc);
            cyc++;
         end
         check("t3_accepted_bound", acc, NW);
      end
      load_valid = 0;
      check("t3_done", {31'd0, load_done}, 32'd1);
      check("t3_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      for (int a = 0; a < NW; a++) begin
         MAR = AW'(a); step();
         check($sformatf("t3_ram%0d", a), {22'd0, MDROut}, {22'd0, img[a]});
      end

      // CPU write in RUN is read-before-write; writes in HOLD are ignored
      MAR = 6'd10; MDRIn = 10'h2AA; RAMWr = 1; step();
      check("t4_old_data", {22'd0, MDROut}, {22'd0, img[10]});
      RAMWr = 0; step();
      check("t4_new_data", {22'd0, MDROut}, 32'h2AA);
      do_reset();
      MAR = 6'd10; MDRIn = 10'h155; RAMWr = 1; step();
      RAMWr = 0; step();
      check("t4_hold_ignored", {22'd0, MDROut}, 32'h2AA);
      img[10] = 10'h2AA;

      // Reset after 20 words then run_start: partial image kept
      load_start = 1; step(); load_start = 0;
      for (int i = 0; i < 20; i++) begin
         img2[i] = DW'($urandom_range(0, 1023));
         load_valid = 1; load_data = img2[i]; step();
      end
      load_valid = 0;
      do_reset();
      run_start = 1; step(); run_start = 0;
      check("t5_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      check("t5_done", {31'd0, load_done}, 32'd0);
      for (int a = 0; a < NW; a++) begin
         MAR = AW'(a); step();
         check($sformatf("t5_ram%0d", a), {22'd0, MDROut},
               {22'd0, (a < 20) ? img2[a] : img[a]});
      end

      // Tiny program run by a bench-side accumulator CPU
      for (int i = 0; i < NW; i++) prog[i] = '0;
      prog[0] = 10'h00A; prog[1] = 10'h08B; prog[2] = 10'h04C; prog[3] = 10'h240;
      prog[10] = 10'd5; prog[11] = 10'd7;
      do_reset();
      load_image(prog);
      begin
         int pc = 0;
         logic [DW-1:0] acc = '0;
         logic [DW-1:0] ir;
         bit halted = 0;
         for (int n = 0; n < 16 && !halted; n++) begin
            MAR = AW'(pc); step(); ir = MDROut;
            case (ir[9:6])
               4'd0: begin MAR = ir[5:0]; step(); acc = MDROut; end
               4'd2: begin MAR = ir[5:0]; step(); acc = acc + MDROut; end
               4'd1: begin MAR = ir[5:0]; MDRIn = acc; RAMWr = 1; step(); RAMWr = 0; end
               default: halted = 1;
            endcase
            pc++;
         end
         check("t6_halted", {31'd0, halted}, 32'd1);
         check("t6_halt_pc", pc, 4);
      end
      MAR = 6'd12; step();
      check("t6_ram12", {22'd0, MDROut}, 32'd12);
      load_start = 1; step(); load_start = 0;
      check("t6_cpu_rst_reasserted", {31'd0, cpu_rst}, 32'd1);
      check("t6_done_cleared", {31'd0, load_done}, 32'd0);
      check("t6_ready", {31'd0, load_ready}, 32'd1);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom_range(0, 63) == 0);
         load_start = ($urandom_range(0, 47) == 0);
         run_start  = ($urandom_range(0, 15) == 0);
         load_valid = $urandom_range(0, 1);
         load_data  = DW'($urandom_range(0, 1023));
         RAMWr      = $urandom_range(0, 1);
         MAR        = AW'($urandom_range(0, NW - 1));
         MDRIn      = DW'($urandom_range(0, 1023));
         step();
      end
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
